// File: rtl/digital_crown_encoder_pkg.sv
// Shared types and constants for the digital crown front-end: setting FSM states,
// strobe bit positions and the quadrature step decoder.
package digital_crown_encoder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHour = 2'd1,
    StMin  = 2'd2,
    StSec  = 2'd3
  } crown_state_e;

  localparam int unsigned HOUR_STROBE = 2;
  localparam int unsigned MIN_STROBE  = 1;
  localparam int unsigned SEC_STROBE  = 0;

  // {A,B} step: +1 clockwise (00->01->11->10->00), -1 reverse, 0 for none or invalid.
  function automatic logic [1:0] quad_delta(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return 2'b01;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: return 2'b11;
      default:                                return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/crown_debouncer.sv
// Push-switch conditioner: 2-FF synchroniser, stable-count filter and a one-cycle
// pulse on each accepted rising level.
module crown_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            r_s1;
  logic            r_s2;
  logic            r_level;
  logic            r_press;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_in;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
        // Final consecutive differing cycle: accept the new level.
        r_level <= r_s2;
        r_press <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/digital_crown_encoder.sv
// Digital crown front-end: quadrature decode into a saturating 10-bit position and a
// push-driven setting sequence issuing one-hot strobes to the clock block.
module digital_crown_encoder
  import digital_crown_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CROWN_STEP      = 4,
  parameter int unsigned CROWN_MAX       = 1023,
  parameter int unsigned PULSE_CYCLES    = 1
) (
  input  logic       CLOCK_50MHz,
  input  logic       RESET,
  input  logic       Enable,
  input  logic       crown_A,
  input  logic       crown_B,
  input  logic       crown_push,
  output logic [9:0] DigitalCrownData,
  output logic       settingTrigger,
  output logic [2:0] settingSig_3bit,
  output logic [1:0] setting_field
);

  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic [1:0]    r_ab_s1, r_ab_s2, r_ab_prev;
  logic          r_primed;
  logic [2:0]    r_sub;
  logic [1:0]    r_det_pend;
  logic [9:0]    r_data;
  crown_state_e  r_state;
  logic          r_trig;
  logic [2:0]    r_sig;
  logic [PW-1:0] r_pcnt;
  logic          r_pend;

  logic          w_press;
  logic [1:0]    w_delta;
  logic [3:0]    w_sub_sum;
  logic          w_det_up, w_det_dn;
  logic [2:0]    w_det, w_total;
  logic [1:0]    w_mag, w_pend_next;
  logic [10:0]   w_stepv, w_up;
  logic [9:0]    w_data_next;
  logic          w_strobe_on, w_strobe_end, w_go, w_start, w_hold;

  crown_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_push_db (
    .i_clk  (CLOCK_50MHz),
    .i_rst  (RESET),
    .i_in   (crown_push),
    .o_press(w_press)
  );

  // Sub-count is widened to 4 bits so +4 is detectable before it wraps.
  assign w_delta   = r_primed ? quad_delta(r_ab_prev, r_ab_s2) : 2'b00;
  assign w_sub_sum = {r_sub[2], r_sub} + {{2{w_delta[1]}}, w_delta};
  assign w_det_up  = (w_sub_sum == 4'b0100);
  assign w_det_dn  = (w_sub_sum == 4'b1100);
  assign w_det     = w_det_up ? 3'b001 : (w_det_dn ? 3'b111 : 3'b000);
  assign w_total   = {r_det_pend[1], r_det_pend} + w_det;

  always_comb begin
    w_mag       = 2'd0;
    w_pend_next = w_total[1:0];
    case (w_total)
      3'b001, 3'b111: w_mag = 2'd1;
      3'b010:         begin w_mag = 2'd2; w_pend_next = 2'b01; end
      3'b110:         begin w_mag = 2'd2; w_pend_next = 2'b11; end
      default:        w_mag = 2'd0;
    endcase
  end

  assign w_stepv = 11'(w_mag) * 11'(CROWN_STEP);
  assign w_up    = {1'b0, r_data} + w_stepv;

  always_comb begin
    w_data_next = r_data;
    if (w_total[2]) begin
      w_data_next = ({1'b0, r_data} < w_stepv) ? 10'd0 : 10'({1'b0, r_data} - w_stepv);
    end else if (w_up > 11'(CROWN_MAX)) begin
      w_data_next = 10'(CROWN_MAX);
    end else begin
      w_data_next = w_up[9:0];
    end
  end

  assign w_strobe_on  = r_trig | (|r_sig);
  assign w_strobe_end = w_strobe_on && (r_pcnt == PW'(PULSE_CYCLES - 1));
  assign w_go         = !w_strobe_on && (w_press || r_pend);
  assign w_start      = w_go && ((r_state != StIdle) || Enable);
  // Position is frozen from the strobe's rising edge until the edge it falls.
  assign w_hold       = w_start || (w_strobe_on && !w_strobe_end);

  always_ff @(posedge CLOCK_50MHz) begin
    if (RESET) begin
      r_ab_s1    <= 2'b00;
      r_ab_s2    <= 2'b00;
      r_ab_prev  <= 2'b00;
      r_primed   <= 1'b0;
      r_sub      <= 3'b000;
      r_det_pend <= 2'b00;
      r_data     <= 10'd0;
      r_state    <= StIdle;
      r_trig     <= 1'b0;
      r_sig      <= 3'b000;
      r_pcnt     <= '0;
      r_pend     <= 1'b0;
    end else begin
      r_ab_s1   <= {crown_A, crown_B};
      r_ab_s2   <= r_ab_s1;
      r_ab_prev <= r_ab_s2;
      r_primed  <= 1'b1;
      r_sub     <= (w_det_up || w_det_dn) ? 3'b000 : w_sub_sum[2:0];

      if (w_hold) begin
        r_det_pend <= w_pend_next;
      end else begin
        r_data     <= w_data_next;
        r_det_pend <= 2'b00;
      end

      if (w_strobe_on) begin
        if (w_strobe_end) begin
          r_trig <= 1'b0;
          r_sig  <= 3'b000;
          r_pcnt <= '0;
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
        if (w_press) r_pend <= 1'b1;
      end else if (w_go) begin
        r_pend <= 1'b0;
        case (r_state)
          StIdle: if (Enable) begin
            r_trig  <= 1'b1;
            r_state <= StHour;
          end
          StHour: begin
            r_sig[HOUR_STROBE] <= 1'b1;
            r_state            <= StMin;
          end
          StMin: begin
            r_sig[MIN_STROBE] <= 1'b1;
            r_state           <= StSec;
          end
          default: begin
            r_sig[SEC_STROBE] <= 1'b1;
            r_state           <= StIdle;
          end
        endcase
      end
    end
  end

  assign DigitalCrownData = r_data;
  assign settingTrigger   = r_trig;
  assign settingSig_3bit  = r_sig;
  assign setting_field    = r_state;

endmodule

// File: tb/tb_digital_crown_encoder.sv
// Directed bench for digital_crown_encoder: rotation, saturation, setting sequence,
// debounce timing, strobe/data hold interaction and mid-sequence reset.
module tb_digital_crown_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ca = 1'b0;
  logic       cb = 1'b0;
  logic       push = 1'b0;
  logic [9:0] data;
  logic       trig;
  logic [2:0] sig;
  logic [1:0] field;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe activity counters, sampled on the falling edge.
  int n_trig = 0, n_h = 0, n_m = 0, n_s = 0, n_multi = 0, n_highs = 0, n_rises = 0;
  logic [3:0] prev_w = 4'b0;

  always #5 clk = ~clk;

  digital_crown_encoder #(
    .DEBOUNCE_CYCLES(8),
    .CROWN_STEP     (4),
    .CROWN_MAX      (1023),
    .PULSE_CYCLES   (1)
  ) dut (
    .CLOCK_50MHz     (clk),
    .RESET           (rst),
    .Enable          (en),
    .crown_A         (ca),
    .crown_B         (cb),
    .crown_push      (push),
    .DigitalCrownData(data),
    .settingTrigger  (trig),
    .settingSig_3bit (sig),
    .setting_field   (field)
  );

  always @(negedge clk) begin
    logic [3:0] w;
    w = {trig, sig};
    if (trig) n_trig++;
    if (sig[2]) n_h++;
    if (sig[1]) n_m++;
    if (sig[0]) n_s++;
    if ($countones(w) > 1) n_multi++;
    n_highs += $countones(w);
    n_rises += $countones(w & ~prev_w);
    prev_w = w;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input logic [1:0] ab);
    {ca, cb} = ab;
    tick(2);
  endtask

  task automatic cw(input int n);
    repeat (n) begin
      step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    end
    tick(3);
  endtask

  task automatic ccw(input int n);
    repeat (n) begin
      step(2'b10); step(2'b11); step(2'b01); step(2'b00);
    end
    tick(3);
  endtask

  task automatic press();
    push = 1'b1;
    tick(16);
    push = 1'b0;
    tick(16);
  endtask

  initial begin
    int t0, h0, m0, s0, hit, n_hit;

    tick(3);
    check_eq("reset_data", 32'(data), 0);
    check_eq("reset_field", 32'(field), 0);
    check_eq("reset_strobes", 32'({trig, sig}), 0);
    rst = 1'b0;
    tick(2);

    // Rotation and saturation.
    t0 = n_highs;
    cw(3);
    check_eq("cw3", 32'(data), 12);
    check_eq("rot_no_strobe", 32'(n_highs - t0), 0);
    ccw(1);
    check_eq("ccw1", 32'(data), 8);
    cw(253);
    check_eq("cw_to_1020", 32'(data), 1020);
    cw(1);
    check_eq("sat_1023", 32'(data), 1023);
    cw(1);
    check_eq("sat_hold", 32'(data), 1023);
    ccw(256);
    check_eq("down_to_0", 32'(data), 0);
    ccw(1);
    check_eq("floor_0", 32'(data), 0);

    // Invalid jumps 00->11->00 must not disturb the sub-count.
    step(2'b11);
    step(2'b00);
    tick(3);
    check_eq("invalid_jump", 32'(data), 0);
    cw(1);
    check_eq("after_invalid", 32'(data), 4);

    // Four clean presses with Enable high.
    en = 1'b1;
    t0 = n_trig; h0 = n_h; m0 = n_m; s0 = n_s;
    press();
    check_eq("p1_field", 32'(field), 1);
    check_eq("p1_trig", 32'(n_trig - t0), 1);
    press();
    check_eq("p2_field", 32'(field), 2);
    check_eq("p2_hour", 32'(n_h - h0), 1);
    press();
    check_eq("p3_field", 32'(field), 3);
    check_eq("p3_min", 32'(n_m - m0), 1);
    press();
    check_eq("p4_field", 32'(field), 0);
    check_eq("p4_sec", 32'(n_s - s0), 1);

    // Bouncing push then stable high: one trigger, 11 cycles after the last edge.
    t0 = n_trig;
    for (int i = 0; i < 40; i++) begin
      push = ((i / 3) % 2 == 0);
      tick(1);
    end
    push = 1'b1;
    hit = 0;
    n_hit = 0;
    for (int j = 1; j <= 20; j++) begin
      tick(1);
      if (trig) begin
        n_hit++;
        if (hit == 0) hit = j;
      end
    end
    check_eq("bounce_latency", 32'(hit), 11);
    check_eq("bounce_one_trig", 32'(n_trig - t0), 1);
    check_eq("bounce_field", 32'(field), 1);
    push = 1'b0;
    tick(16);

    // Enable dropped mid-sequence: sequence still completes.
    en = 1'b0;
    h0 = n_h; m0 = n_m; s0 = n_s;
    press(); press(); press();
    check_eq("noen_hour", 32'(n_h - h0), 1);
    check_eq("noen_min", 32'(n_m - m0), 1);
    check_eq("noen_sec", 32'(n_s - s0), 1);
    check_eq("noen_field", 32'(field), 0);

    // Press with Enable low in idle is discarded.
    t0 = n_trig;
    press();
    check_eq("idle_noen_trig", 32'(n_trig - t0), 0);
    check_eq("idle_noen_field", 32'(field), 0);

    // Detent completing on the edge the hour strobe rises is deferred one edge.
    en = 1'b1;
    press();
    step(2'b01); step(2'b11); step(2'b10);
    tick(3);
    check_eq("pre_detent", 32'(data), 4);
    push = 1'b1;
    tick(8);
    {ca, cb} = 2'b00;
    tick(2);
    check_eq("hold_before", 32'(data), 4);
    check_eq("hold_before_sig", 32'(sig), 0);
    tick(1);
    check_eq("hold_sig_rise", 32'(sig), 4);
    check_eq("hold_data", 32'(data), 4);
    tick(1);
    check_eq("hold_release", 32'(data), 8);
    check_eq("hold_sig_fall", 32'(sig), 0);
    push = 1'b0;
    tick(16);
    check_eq("in_min", 32'(field), 2);

    // Reset while in MIN.
    rst = 1'b1;
    tick(1);
    check_eq("rst_field", 32'(field), 0);
    check_eq("rst_data", 32'(data), 0);
    check_eq("rst_strobes", 32'({trig, sig}), 0);
    rst = 1'b0;
    tick(2);

    check_eq("never_two_strobes", 32'(n_multi), 0);
    check_eq("width_one_cycle", 32'(n_highs), 32'(n_rises));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
